// File: rtl/reflet_prog_loader16_pkg.sv
// Shared definitions for the program loader: widths, frame-order states, write payload.
package reflet_prog_loader16_pkg;

    localparam int unsigned ADDR_W         = 14;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned LOADER_TIMEOUT = 1000000;

    // States follow the frame byte order: LEN_LO, LEN_HI, {DATA_LO, DATA_HI}*, CSUM.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_wr_t;

    function automatic logic is_loading(input state_t s);
        return s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI, ST_CSUM};
    endfunction

endpackage

// File: rtl/reflet_loader_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear, flags the last allowed cycle.
module reflet_loader_timeout
    import reflet_prog_loader16_pkg::*;
#(
    parameter int unsigned timeout_cycles = LOADER_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;

    logic [CNT_W-1:0] count;

    assign expired_c = (count == CNT_W'(timeout_cycles - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reflet_prog_loader16.sv
// Loads a UART byte-stream program image into the 16-bit instruction RAM, word by word.
module reflet_prog_loader16
    import reflet_prog_loader16_pkg::*;
#(
    parameter logic [ADDR_W-1:0] base_addr      = 14'h0000,
    parameter int unsigned       mem_words      = 10000,
    parameter int unsigned       timeout_cycles = LOADER_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_ready,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              write_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned MAX_LEN = mem_words - 32'(base_addr);

    state_t            state, state_d;
    logic [DATA_W-1:0] len, len_d, index, index_d, len_full_c;
    logic [BYTE_W-1:0] low, low_d, sum, sum_d, sum_next_c;
    mem_wr_t           wr, wr_d;
    logic              write_en_d, busy_d, done_d, error_d;
    logic              active_c, abort_c, tmr_clear, expired_c;

    assign active_c   = is_loading(state);
    assign sum_next_c = sum + rx_data;
    assign len_full_c = {rx_data, len[BYTE_W-1:0]};
    assign addr       = wr.addr;
    assign data_out   = wr.data;

    reflet_loader_timeout #(
        .timeout_cycles(timeout_cycles)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .enable   (active_c),
        .expired_c(expired_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            len      <= '0;
            low      <= '0;
            index    <= '0;
            sum      <= '0;
            wr       <= '0;
            write_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_d;
            len      <= len_d;
            low      <= low_d;
            index    <= index_d;
            sum      <= sum_d;
            wr       <= wr_d;
            write_en <= write_en_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
        end
    end

    // Memory re-init and watchdog expiry take priority over any byte arriving that cycle.
    always_comb begin
        state_d    = state;
        len_d      = len;
        low_d      = low;
        index_d    = index;
        sum_d      = sum;
        wr_d       = wr;
        write_en_d = 1'b0;
        busy_d     = busy;
        done_d     = done;
        error_d    = error;
        tmr_clear  = 1'b0;
        abort_c    = 1'b0;

        if (!active_c) begin
            if (start && inst_ready) begin
                state_d   = ST_LEN_LO;
                busy_d    = 1'b1;
                done_d    = 1'b0;
                error_d   = 1'b0;
                sum_d     = '0;
                index_d   = '0;
                tmr_clear = 1'b1;
            end
        end else if (!inst_ready || expired_c) begin
            abort_c = 1'b1;
        end else if (rx_valid) begin
            sum_d     = sum_next_c;
            tmr_clear = 1'b1;
            case (state)
                ST_LEN_LO: begin
                    len_d   = {8'h00, rx_data};
                    state_d = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    len_d = len_full_c;
                    if (32'(len_full_c) > MAX_LEN) begin
                        abort_c = 1'b1;
                    end else if (len_full_c == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    low_d   = rx_data;
                    state_d = ST_DATA_HI;
                end
                ST_DATA_HI: begin
                    write_en_d = 1'b1;
                    wr_d.addr  = ADDR_W'(DATA_W'(base_addr) + index);
                    wr_d.data  = {rx_data, low};
                    index_d    = index + DATA_W'(1);
                    state_d    = (index_d == len) ? ST_CSUM : ST_DATA_LO;
                end
                ST_CSUM: begin
                    if (sum_next_c == '0) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        abort_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (abort_c) begin
            state_d    = ST_ERROR;
            busy_d     = 1'b0;
            error_d    = 1'b1;
            write_en_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_reflet_prog_loader16.sv
// Scoreboarded bench for the program loader: expected writes queued, monitor checks each strobe.
module tb_reflet_prog_loader16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inst_ready = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [13:0] addr;
    logic [15:0] data_out;
    logic        write_en, busy, done, error;

    int checks = 0;
    int errors = 0;
    logic [29:0] exp_q[$];

    always #5 clk = ~clk;

    reflet_prog_loader16 #(
        .base_addr     (14'h0000),
        .mem_words     (16),
        .timeout_cycles(64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .inst_ready(inst_ready),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addr      (addr),
        .data_out  (data_out),
        .write_en  (write_en),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    initial forever begin
        @(negedge clk);
        if (write_en === 1'b1) begin
            logic [29:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", addr, data_out);
            end else begin
                e = exp_q.pop_front();
                check("write", {2'b00, addr, data_out}, {2'b00, e});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("arm_flags", {29'd0, busy, done, error}, 32'h4);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_addr", {18'd0, addr}, 32'h0);
        check("reset_data", {16'd0, data_out}, 32'h0);
        check("reset_flags", {28'd0, write_en, busy, done, error}, 32'h0);
        reset = 1'b1;

        // start ignored until the memory reports ready
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_arm_without_ready", {31'd0, busy}, 32'h0);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        check("arm_on_ready", {31'd0, busy}, 32'h1);
        start = 1'b0;

        // good two-word frame: byte sum 0xC0, checksum 0x40
        exp_q.push_back({14'h0000, 16'h1234});
        exp_q.push_back({14'h0001, 16'hABCD});
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hCD); send_byte(8'hAB);
        send_byte(8'h40);
        check("good_frame_flags", {29'd0, busy, done, error}, 32'h2);
        check("good_frame_drained", exp_q.size(), 32'h0);

        // same frame, bad checksum: writes still happen
        arm();
        exp_q.push_back({14'h0000, 16'h1234});
        exp_q.push_back({14'h0001, 16'hABCD});
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hCD); send_byte(8'hAB);
        send_byte(8'h41);
        check("bad_csum_flags", {29'd0, busy, done, error}, 32'h1);

        // len=17 exceeds 16-word memory
        arm();
        send_byte(8'h11); send_byte(8'h00);
        check("bound_flags", {29'd0, busy, done, error}, 32'h1);
        repeat (3) @(negedge clk);

        // inter-byte timeout
        arm();
        send_byte(8'h05);
        repeat (63) @(negedge clk);
        check("timeout_not_yet", {31'd0, error}, 32'h0);
        @(negedge clk);
        check("timeout_flags", {29'd0, busy, done, error}, 32'h1);

        // reset after first of two words
        arm();
        exp_q.push_back({14'h0000, 16'h1234});
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h34); send_byte(8'h12);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_addr", {18'd0, addr}, 32'h0);
        check("midreset_data", {16'd0, data_out}, 32'h0);
        check("midreset_flags", {28'd0, write_en, busy, done, error}, 32'h0);
        reset = 1'b1;

        // fresh one-word frame: sum 0xCF, checksum 0x31
        arm();
        exp_q.push_back({14'h0000, 16'h5678});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56);
        send_byte(8'h31);
        check("fresh_frame_flags", {29'd0, busy, done, error}, 32'h2);

        // empty frame
        arm();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("empty_frame_flags", {29'd0, busy, done, error}, 32'h2);

        // memory re-init while the high byte arrives: abort, strobe suppressed
        arm();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h34);
        rx_data    = 8'h12;
        rx_valid   = 1'b1;
        inst_ready = 1'b0;
        @(negedge clk);
        rx_valid   = 1'b0;
        inst_ready = 1'b1;
        check("reinit_flags", {29'd0, busy, done, error}, 32'h1);

        repeat (3) @(negedge clk);
        check("all_writes_seen", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
